// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg
//   Shared timing constants for the board key and LED blocks, plus the
//   per-key debounce FSM state type.
//   Contents:
//     CLK_HZ, DEBOUNCE_MS, LONG_MS   - board-level timing defaults
//     DEBOUNCE_CYCLES, LONG_CYCLES   - the same timings in clk cycles
//     key_fsm_t                      - per-key debounce state
package key_debounce_pkg;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEBOUNCE_MS = 20;
    localparam int unsigned LONG_MS     = 1000;

    localparam int unsigned CYCLES_PER_MS   = CLK_HZ / 1000;
    localparam int unsigned DEBOUNCE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS;
    localparam int unsigned LONG_CYCLES     = CYCLES_PER_MS * LONG_MS;

    typedef enum logic [1:0] {
        KEY_RELEASED,
        KEY_PRESS_WAIT,
        KEY_PRESSED,
        KEY_RELEASE_WAIT
    } key_fsm_t;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
//   One key channel: 2-flop synchronizer, debounce filter, press/release
//   pulses and a single long-press pulse.
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   synchronous active-high reset
//     key_n        in   raw key pin, 0 = pressed
//     key_state    out  debounced level, 1 = pressed
//     key_press    out  one-cycle pulse on accepted press
//     key_release  out  one-cycle pulse on accepted release
//     key_long     out  one-cycle pulse once a press has been held LONG_CNT cycles
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CNT     = LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned   CW        = $clog2(DEBOUNCE_CNT);
    localparam int unsigned   HW        = $clog2(LONG_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CNT);

    logic          s1, s2;
    logic          lvl;
    key_fsm_t      state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic          pressed;
    logic          press_nxt, release_nxt, long_nxt;
    logic          press_q, release_q, long_q;

    // Synchronized pin level in pressed-high polarity.
    assign lvl = ~s2;

    // State register, counters, synchronizer and pulse registers.
    // Synchronizer resets to "released" so no press is seen out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            state     <= KEY_RELEASED;
            cnt       <= '0;
            hold      <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            s1        <= key_n;
            s2        <= s1;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            long_q    <= long_nxt;
        end
    end

    // Next state and debounce count. The count is the number of consecutive
    // cycles the synchronized level has disagreed with the accepted level;
    // any agreeing cycle drops it back to zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            KEY_RELEASED: begin
                if (lvl) begin
                    state_nxt = KEY_PRESS_WAIT;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            KEY_PRESS_WAIT: begin
                if (!lvl)                 state_nxt = KEY_RELEASED;
                else if (cnt == CNT_LAST) state_nxt = KEY_PRESSED;
                else                      cnt_nxt   = cnt + 1'b1;
            end
            KEY_PRESSED: begin
                if (!lvl) begin
                    state_nxt = KEY_RELEASE_WAIT;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            KEY_RELEASE_WAIT: begin
                if (lvl)                  state_nxt = KEY_PRESSED;
                else if (cnt == CNT_LAST) state_nxt = KEY_RELEASED;
                else                      cnt_nxt   = cnt + 1'b1;
            end
            default: state_nxt = KEY_RELEASED;
        endcase
    end

    // Outputs and hold counter. The hold count is zero on the press edge
    // because key_state was still 0 in the cycle before it, so key_long lands
    // LONG_CNT cycles after key_press. A long pulse is withheld on the cycle
    // the release is accepted so it never coincides with key_release.
    always_comb begin
        pressed     = (state == KEY_PRESSED) || (state == KEY_RELEASE_WAIT);
        press_nxt   = (state == KEY_PRESS_WAIT)   && (state_nxt == KEY_PRESSED);
        release_nxt = (state == KEY_RELEASE_WAIT) && (state_nxt == KEY_RELEASED);
        hold_nxt    = '0;
        if (pressed) begin
            hold_nxt = (hold == HOLD_MAX) ? hold : hold + 1'b1;
        end
        long_nxt = pressed && (hold == HOLD_LAST) && !release_nxt;
    end

    assign key_state   = pressed;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce
//   Conditions NUM_KEYS active-low push-buttons into clean, clock-synchronous
//   key events; one independent key_debounce_ch per key.
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   synchronous active-high reset
//     key_n        in   raw key pins, 0 = pressed
//     key_state    out  debounced levels, 1 = pressed
//     key_press    out  one-cycle pulse per key on accepted press
//     key_release  out  one-cycle pulse per key on accepted release
//     key_long     out  one-cycle pulse per key after LONG_CNT cycles held
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CNT     = LONG_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_ch #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .LONG_CNT     (LONG_CNT)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_n       (key_n[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed stimulus for key_debounce with a window-based reference model:
//   a key's accepted level flips when the last DB synchronized samples all
//   disagree with it; key_long is due exactly LG cycles after the press if
//   the key is still held.
module tb_key_debounce;

    localparam int NK = 4;
    localparam int DB = 8;
    localparam int LG = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_state, key_press, key_release, key_long;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    key_debounce #(
        .NUM_KEYS     (NK),
        .DEBOUNCE_CNT (DB),
        .LONG_CNT     (LG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]    m_sync [NK];
    logic [DB-1:0] m_hist [NK];
    int            m_len  [NK];
    int            m_pcyc [NK];
    logic [NK-1:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0;
    logic          m_lvl;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NK; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            m_long[i]  = 1'b0;
            if (reset) begin
                m_sync[i]  = 2'b11;
                m_hist[i]  = '0;
                m_len[i]   = 0;
                m_state[i] = 1'b0;
                m_pcyc[i]  = -1;
            end else begin
                m_lvl     = ~m_sync[i][1];
                m_hist[i] = {m_hist[i][DB-2:0], m_lvl};
                if (m_len[i] < DB) m_len[i]++;
                if (m_len[i] == DB && m_hist[i] == {DB{~m_state[i]}}) begin
                    if (m_state[i]) begin
                        m_rel[i]   = 1'b1;
                        m_state[i] = 1'b0;
                        m_pcyc[i]  = -1;
                    end else begin
                        m_press[i] = 1'b1;
                        m_state[i] = 1'b1;
                        m_pcyc[i]  = cyc;
                    end
                end else if (m_state[i] && m_pcyc[i] >= 0 && cyc == m_pcyc[i] + LG) begin
                    m_long[i] = 1'b1;
                end
                m_sync[i] = {m_sync[i][0], key_n[i]};
            end
        end
    end

    // ---------------- per-cycle compare + pulse tallies ----------------
    int press_seen [NK];
    int rel_seen   [NK];
    int long_seen  [NK];

    initial begin
        for (int i = 0; i < NK; i++) begin
            press_seen[i] = 0;
            rel_seen[i]   = 0;
            long_seen[i]  = 0;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("key_state",   key_state,   m_state);
            check("key_press",   key_press,   m_press);
            check("key_release", key_release, m_rel);
            check("key_long",    key_long,    m_long);
            for (int i = 0; i < NK; i++) begin
                if (key_press[i] === 1'b1)   press_seen[i]++;
                if (key_release[i] === 1'b1) rel_seen[i]++;
                if (key_long[i] === 1'b1)    long_seen[i]++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset for 3 edges, then idle.
        adv(3);
        check("rst_state", key_state, 4'b0000);
        check("rst_press", key_press, 4'b0000);
        check("rst_long",  key_long,  4'b0000);
        reset = 1'b0;
        adv(20);
        check_int("idle_press_cnt0", press_seen[0] + press_seen[1] + press_seen[2] + press_seen[3], 0);
        check("idle_state", key_state, 4'b0000);

        // Key 0 clean press: accepted 10 edges after the change.
        key_n[0] = 1'b0;
        adv(9);
        check("k0_press_early", key_press, 4'b0000);
        adv(1);
        check("k0_press", key_press, 4'b0001);
        check("k0_state", key_state, 4'b0001);
        adv(1);
        check("k0_press_gone", key_press, 4'b0000);
        key_n[0] = 1'b1;
        adv(15);
        check("k0_released", key_state, 4'b0000);

        // Key 1 bouncing press, then bouncing release.
        key_n[1] = 1'b0; adv(3);
        key_n[1] = 1'b1; adv(3);
        key_n[1] = 1'b0; adv(3);
        key_n[1] = 1'b1; adv(3);
        check_int("k1_bounce_no_press", press_seen[1], 0);
        key_n[1] = 1'b0;
        adv(9);
        check("k1_press_early", key_press, 4'b0000);
        adv(1);
        check("k1_press", key_press, 4'b0010);
        adv(5);
        key_n[1] = 1'b1; adv(3);
        key_n[1] = 1'b0; adv(3);
        key_n[1] = 1'b1; adv(3);
        key_n[1] = 1'b0; adv(3);
        check("k1_bounce_held", key_state, 4'b0010);
        key_n[1] = 1'b1;
        adv(9);
        check("k1_release_early", key_release, 4'b0000);
        adv(1);
        check("k1_release", key_release, 4'b0010);
        check_int("k1_press_cnt", press_seen[1], 1);

        // Key 2 held 60 cycles: press, one long pulse, release.
        adv(5);
        key_n[2] = 1'b0;
        adv(10);
        check("k2_press", key_press, 4'b0100);
        adv(31);
        check("k2_long_early", key_long, 4'b0000);
        adv(1);
        check("k2_long", key_long, 4'b0100);
        adv(1);
        check("k2_long_gone", key_long, 4'b0000);
        adv(17);
        key_n[2] = 1'b1;
        adv(10);
        check("k2_release", key_release, 4'b0100);
        check_int("k2_long_cnt", long_seen[2], 1);

        // Key 3 released after 20 cycles pressed: no long.
        adv(5);
        key_n[3] = 1'b0;
        adv(10);
        check("k3_press", key_press, 4'b1000);
        adv(20);
        key_n[3] = 1'b1;
        adv(10);
        check("k3_release", key_release, 4'b1000);
        adv(40);
        check_int("k3_long_cnt", long_seen[3], 0);

        // Key 0 held through a mid-press reset.
        key_n[0] = 1'b0;
        adv(15);
        check("k0b_state", key_state, 4'b0001);
        reset = 1'b1;
        adv(5);
        check("rst2_state", key_state, 4'b0000);
        reset = 1'b0;
        adv(9);
        check("k0b_press_early", key_press, 4'b0000);
        adv(1);
        check("k0b_press", key_press, 4'b0001);
        key_n = '1;
        adv(20);
        check("final_state", key_state, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
